// File: rtl/lstm_mem_pkg.sv
// Shared definitions for the LSTM hidden-state memory readers: FSM encoding,
// address width and the (t, n, last) tag carried alongside each streamed word.
package lstm_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int T_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  typedef struct packed {
    logic [T_W-1:0]    t;
    logic [ADDR_W-1:0] n;
    logic              last;
  } beat_tag_t;

  function automatic beat_tag_t make_tag(input logic [T_W-1:0] t,
                                         input logic [ADDR_W-1:0] n,
                                         input logic last);
    beat_tag_t tag;
    tag.t    = t;
    tag.n    = n;
    tag.last = last;
    return tag;
  endfunction

endpackage

// File: rtl/h_mem_reader_if.sv
// Shared-memory read port plus the tagged h-value stream towards backprop.
interface h_mem_reader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
);
  logic        [ADDR_W-1:0]            rd_addr;
  logic                                mem_wr;
  logic signed [WIDTH-1:0]             mem_o;
  logic signed [WIDTH-1:0]             o_data;
  logic        [lstm_mem_pkg::T_W-1:0] o_t;
  logic        [ADDR_W-1:0]            o_n;
  logic                                o_last;
  logic                                o_valid;
  logic                                o_ready;

  modport master (
    output rd_addr,
    input  mem_wr,
    input  mem_o,
    output o_data,
    output o_t,
    output o_n,
    output o_last,
    output o_valid,
    input  o_ready
  );

  modport slave (
    input  rd_addr,
    output mem_wr,
    output mem_o,
    input  o_data,
    input  o_t,
    input  o_n,
    input  o_last,
    input  o_valid,
    output o_ready
  );
endinterface

// File: rtl/h_skid_fifo.sv
// Two-entry FIFO holding captured memory words with their tags; the head
// entry is presented directly from registers.
module h_skid_fifo #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head_data,
  output logic [TAG_W-1:0] head_tag
);

  logic [1:0][WIDTH-1:0] data_q, data_d;
  logic [1:0][TAG_W-1:0] tag_q, tag_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  pop_ok_s;
  logic                  push_ok_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    pop_ok_s  = pop && (count_q != 2'd0);
    push_ok_s = push && ((count_q != 2'd2) || pop_ok_s);
    data_d    = data_q;
    tag_d     = tag_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok_s) begin
      data_d[wr_ptr_q] = push_data;
      tag_d[wr_ptr_q]  = push_tag;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      tag_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count     = count_q;
  assign head_data = data_q[rd_ptr_q];
  assign head_tag  = tag_q[rd_ptr_q];

endmodule

// File: rtl/h_mem_reader.sv
// BPTT-order reader of the LSTM h memory (t high->low, n low->high) with a
// credit-limited read pipeline. Optional HREAD_STALL_CNT_EN adds stall_cnt.
module h_mem_reader
  import lstm_mem_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_LSTM = 53,
  parameter int TIMESTEP = 7,
  parameter int ADDR_W   = lstm_mem_pkg::ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
`ifdef HREAD_STALL_CNT_EN
  output logic [15:0]   stall_cnt,
`endif
  h_mem_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(TIMESTEP * NUM_LSTM);
  localparam logic [ADDR_W-1:0] REWIND     = ADDR_W'(2 * NUM_LSTM - 1);
  localparam logic [ADDR_W-1:0] N_LAST     = ADDR_W'(NUM_LSTM - 1);
  localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
  localparam logic [T_W-1:0]    T_TOP      = T_W'(TIMESTEP);

  rd_state_e         state_q, state_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              inflight_q, inflight_d;
  beat_tag_t         inflight_tag_q, inflight_tag_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]        fifo_count_s;
  logic [WIDTH-1:0]  head_data_s;
  beat_tag_t         head_tag_s;
  logic              o_valid_s;
  logic              pop_s;
  logic [2:0]        occ_s;
  logic              start_ok_s;
  logic              issue_try_s;
  logic              issue_ok_s;
  logic              last_issue_s;

  // Occupancy counts the beat popped this cycle as gone, so a steady
  // stream keeps one read in flight every cycle.
  assign o_valid_s    = (fifo_count_s != 2'd0);
  assign pop_s        = o_valid_s & bus.o_ready;
  assign occ_s        = {1'b0, fifo_count_s} - {2'b00, pop_s} + {2'b00, inflight_q};
  assign start_ok_s   = (state_q == IDLE) & start;
  assign issue_try_s  = (state_q == RUN) & (occ_s < 3'd2);
  assign issue_ok_s   = issue_try_s & ~bus.mem_wr;
  assign last_issue_s = (t_q == {T_W{1'b0}}) & (n_q == N_LAST);

  // Sequencer next-state: counters, running address and read pipeline.
  always_comb begin
    state_d        = state_q;
    t_d            = t_q;
    n_d            = n_q;
    rd_addr_d      = rd_addr_q;
    inflight_d     = 1'b0;
    inflight_tag_d = inflight_tag_q;
    case (state_q)
      IDLE: begin
        if (start_ok_s) begin
          state_d   = RUN;
          t_d       = T_TOP;
          n_d       = {ADDR_W{1'b0}};
          rd_addr_d = FIRST_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (issue_ok_s) begin
          inflight_d     = 1'b1;
          inflight_tag_d = make_tag(t_q, n_q, last_issue_s);
          if (last_issue_s) begin
            state_d = DRAIN;
          end else if (n_q == N_LAST) begin
            n_d       = {ADDR_W{1'b0}};
            t_d       = t_q - 4'd1;
            rd_addr_d = rd_addr_q - REWIND;
          end else begin
            n_d       = n_q + ONE_A;
            rd_addr_d = rd_addr_q + ONE_A;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (occ_s == 3'd0) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      t_q            <= {T_W{1'b0}};
      n_q            <= {ADDR_W{1'b0}};
      rd_addr_q      <= {ADDR_W{1'b0}};
      inflight_q     <= 1'b0;
      inflight_tag_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      t_q            <= t_d;
      n_q            <= n_d;
      rd_addr_q      <= rd_addr_d;
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  h_skid_fifo #(
    .WIDTH (WIDTH),
    .TAG_W ($bits(beat_tag_t))
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (bus.mem_o),
    .push_tag  (inflight_tag_q),
    .pop       (pop_s),
    .count     (fifo_count_s),
    .head_data (head_data_s),
    .head_tag  (head_tag_s)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.o_data  = head_data_s;
  assign bus.o_t     = head_tag_s.t;
  assign bus.o_n     = head_tag_s.n;
  assign bus.o_last  = head_tag_s.last;
  assign bus.o_valid = o_valid_s;

`ifdef HREAD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of issue attempts lost to memory writes.
  always_comb begin
    if (start_ok_s) begin
      stall_cnt_d = 16'h0000;
    end else if (issue_try_s && bus.mem_wr && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'h0001;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_h_mem_reader.sv
// Directed bench: a small instance (NUM_LSTM=3, TIMESTEP=2) for sequencing,
// stalls, backpressure and reset, plus a default-parameter instance.
module tb_h_mem_reader;

  localparam int W   = 32;
  localparam int AW  = 12;
  localparam int NL  = 3;
  localparam int TS  = 2;
  localparam int NL2 = 53;
  localparam int TS2 = 7;

  localparam int M_NORM    = 0;
  localparam int M_STALL   = 1;
  localparam int M_BP      = 2;
  localparam int M_RESTART = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic start2 = 1'b0;
  logic busy2, done2;
`ifdef HREAD_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt;
  int wr8_cnt;
  logic [AW-1:0] addr_q[$];
  logic [63:0]   got_beat[$];
  int            got_cyc[$];

  always #5 clk = ~clk;

  h_mem_reader_if #(.WIDTH(W), .ADDR_W(AW)) bus ();
  h_mem_reader_if #(.WIDTH(W), .ADDR_W(AW)) bus2 ();

  h_mem_reader #(.WIDTH(W), .NUM_LSTM(NL), .TIMESTEP(TS), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
`ifdef HREAD_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus   (bus)
  );

  h_mem_reader #(.WIDTH(W), .NUM_LSTM(NL2), .TIMESTEP(TS2), .ADDR_W(AW)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start2),
    .busy  (busy2),
    .done  (done2),
`ifdef HREAD_STALL_CNT_EN
    .stall_cnt (stall_cnt2),
`endif
    .bus   (bus2)
  );

  // Memory models: data[a] = 0x100 + a; a read during a write returns junk.
  always @(posedge clk) begin
    bus.mem_o  <= bus.mem_wr  ? 32'hDEAD_BEEF : (32'h100 + 32'(bus.rd_addr));
    bus2.mem_o <= bus2.mem_wr ? 32'hDEAD_BEEF : (32'h100 + 32'(bus2.rd_addr));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_beat(input logic [31:0] d, input int t, input int n,
                                            input logic last);
    return {15'd0, d, 4'(t), 12'(n), last};
  endfunction

  task automatic clear_log();
    addr_q.delete();
    got_beat.delete();
    got_cyc.delete();
    done_cnt = 0;
    wr8_cnt  = 0;
  endtask

  // One cycle of the small instance: drive inputs at negedge, then log outputs.
  task automatic tick(input logic st, input logic wr, input logic rdy, input logic rs);
    @(negedge clk);
    start       = st;
    bus.mem_wr  = wr;
    bus.o_ready = rdy;
    rst         = rs;
    cyc++;
    if (!rs) begin
      if (busy && (addr_q.size() == 0 || addr_q[$] != bus.rd_addr)) addr_q.push_back(bus.rd_addr);
      if (busy && bus.rd_addr == 12'd8 && wr) wr8_cnt++;
      if (bus.o_valid && rdy) begin
        got_beat.push_back({15'd0, bus.o_data, bus.o_t, bus.o_n, bus.o_last});
        got_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        check_val("busy_at_done", 64'(busy), 64'd0);
      end
    end
  endtask

  task automatic check_beats(input string name, input int nbeats);
    int t, n, a;
    check_val({name, "_beat_count"}, 64'(got_beat.size()), 64'(nbeats));
    check_val({name, "_addr_count"}, 64'(addr_q.size()), 64'(NL * (TS + 1)));
    for (int i = 0; i < nbeats && i < got_beat.size(); i++) begin
      t = TS - i / NL;
      n = i % NL;
      a = t * NL + n;
      check_val($sformatf("%s_beat%0d", name, i), got_beat[i],
                pack_beat(32'h100 + 32'(a), t, n, i == NL * (TS + 1) - 1));
    end
    for (int i = 0; i < addr_q.size() && i < NL * (TS + 1); i++) begin
      a = (TS - i / NL) * NL + i % NL;
      check_val($sformatf("%s_addr%0d", name, i), 64'(addr_q[i]), 64'(a));
    end
  endtask

  task automatic run_small(input int mode, input string name);
    int k;
    logic st, wr, rdy;
    clear_log();
    k = 0;
    while (done_cnt == 0 && k < 200) begin
      st  = (k == 0) || (mode == M_RESTART && (k == 5 || k == 9));
      wr  = (mode == M_STALL) && (k >= 3) && (k <= 5);
      rdy = 1'b1;
      if (mode == M_BP) begin
        if (k < 12) rdy = (k % 2 == 0);
        else if (k < 17) rdy = 1'b0;
        else rdy = 1'b1;
      end
      tick(st, wr, rdy, 1'b0);
      k++;
    end
    check_val({name, "_no_timeout"}, 64'(k < 200), 64'd1);
    repeat (4) tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_val({name, "_done_once"}, 64'(done_cnt), 64'd1);
    check_beats(name, NL * (TS + 1));
  endtask

  initial begin
    int k, idx, t, n, first2, c0, c1;
    bus.mem_wr   = 1'b0;
    bus.o_ready  = 1'b1;
    bus2.mem_wr  = 1'b0;
    bus2.o_ready = 1'b1;
    clear_log();

    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("rst_busy",    64'(busy),        64'd0);
    check_val("rst_done",    64'(done),        64'd0);
    check_val("rst_o_valid", 64'(bus.o_valid), 64'd0);
    check_val("rst_rd_addr", 64'(bus.rd_addr), 64'd0);
    check_val("rst_o_data",  64'(bus.o_data),  64'd0);
    check_val("rst_o_t",     64'(bus.o_t),     64'd0);
    check_val("rst_o_n",     64'(bus.o_n),     64'd0);
    check_val("rst_o_last",  64'(bus.o_last),  64'd0);

    run_small(M_NORM, "norm");
    if (got_cyc.size() == 9) check_val("norm_back_to_back", 64'(got_cyc[8] - got_cyc[0]), 64'd8);
    else check_val("norm_cyc_log", 64'(got_cyc.size()), 64'd9);
`ifdef HREAD_STALL_CNT_EN
    check_val("norm_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    run_small(M_STALL, "stall");
    check_val("stall_addr8_hold", 64'(wr8_cnt), 64'd3);
`ifdef HREAD_STALL_CNT_EN
    check_val("stall_cnt", 64'(stall_cnt), 64'd3);
`endif

    run_small(M_BP, "bp");
    run_small(M_RESTART, "restart");

    // Reset in the middle of a run, after four accepted beats.
    clear_log();
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    k = 0;
    while (got_beat.size() < 4 && k < 50) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      k++;
    end
    check_val("mid_rst_reach4", 64'(k < 50), 64'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("mid_rst_busy",    64'(busy),        64'd0);
    check_val("mid_rst_o_valid", 64'(bus.o_valid), 64'd0);
    repeat (20) tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_val("mid_rst_no_done", 64'(done_cnt), 64'd0);
    check_val("mid_rst_beats",   64'(got_beat.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_beat.size(); i++) begin
      t = TS - i / NL;
      n = i % NL;
      check_val($sformatf("mid_rst_beat%0d", i), got_beat[i],
                pack_beat(32'h100 + 32'(t * NL + n), t, n, 1'b0));
    end
    run_small(M_NORM, "replay");

    // Default-parameter instance: 424 beats starting at address 371.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    first2 = 32'(bus2.rd_addr);
    check_val("dflt_busy", 64'(busy2), 64'd1);
    check_val("dflt_first_addr", 64'(first2), 64'd371);
    idx = 0;
    k   = 0;
    c0  = 0;
    c1  = 0;
    done_cnt = 0;
    while (done_cnt == 0 && k < 1000) begin
      if (bus2.o_valid) begin
        t = TS2 - idx / NL2;
        n = idx % NL2;
        if (idx == 0) c0 = k;
        c1 = k;
        check_val($sformatf("dflt_beat%0d", idx),
                  {15'd0, bus2.o_data, bus2.o_t, bus2.o_n, bus2.o_last},
                  pack_beat(32'h100 + 32'(t * NL2 + n), t, n, idx == NL2 * (TS2 + 1) - 1));
        idx++;
      end
      if (done2) begin
        done_cnt++;
        check_val("dflt_busy_at_done", 64'(busy2), 64'd0);
      end
      @(negedge clk);
      k++;
    end
    check_val("dflt_no_timeout", 64'(k < 1000), 64'd1);
    check_val("dflt_beat_count", 64'(idx), 64'd424);
    check_val("dflt_back_to_back", 64'(c1 - c0), 64'd423);
`ifdef HREAD_STALL_CNT_EN
    check_val("dflt_stall_cnt", 64'(stall_cnt2), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/h_mem_reader.md
Name: h_mem_reader

Overview:
- Read-side sequencer for the LSTM hidden-state memory, which holds NUM_LSTM words per slot for TIMESTEP+1 slots. Layout is addr = t*NUM_LSTM + n; slot 0 is the initial h.
- On a start pulse it walks the memory in BPTT order: t from TIMESTEP down to 0, and n from 0 up to NUM_LSTM-1 within each t.
- It drives rd_addr, captures the one-cycle-latency memory output and delivers each word on a valid/ready stream tagged with (t, n) to the backprop datapath.
- It tolerates memory write cycles, which block reads, and downstream backpressure.

Parameters:
- WIDTH, 32, data word width.
- NUM_LSTM, 53, cells per timestep slot.
- TIMESTEP, 7, highest slot index; the block performs NUM_LSTM*(TIMESTEP+1) reads per run.
- ADDR_W, 12, memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the final beat is accepted
- mem_wr  in  1  write enable currently driven onto the shared memory; a read issued while it is high is lost
- rd_addr  out  ADDR_W  memory read address
- mem_o  in  WIDTH signed  memory read data
- o_data  out  WIDTH signed  streamed h value
- o_t  out  4  timestep slot of o_data
- o_n  out  ADDR_W  cell index of o_data
- o_last  out  1  marks the final beat (t=0, n=NUM_LSTM-1)
- o_valid  out  1  stream valid
- o_ready  in  1  stream ready

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: busy=0, done=0, o_valid=0, rd_addr=0, o_data=0, o_t=0, o_n=0, o_last=0; FSM in IDLE; skid buffer empty; no read in flight.
- Reset asserted mid-run aborts the run. No done pulse is produced, and data already buffered is discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Counters load to t=TIMESTEP, n=0, and rd_addr = TIMESTEP*NUM_LSTM.
  - start is ignored in every state other than IDLE.
  - RUN -> DRAIN once the last address has been issued successfully.
  - DRAIN -> DONE when no read is in flight, the buffer is empty and the last beat has been accepted.
  - DONE -> IDLE after one cycle. done=1 during DONE only.
- Read issue: an issue attempt happens in a cycle where the FSM is in RUN and buffered+inflight < 2.
  - The attempt succeeds only if mem_wr=0 in that cycle.
  - On success: inflight is set for the next cycle, and the counters advance. n increments; at n=NUM_LSTM-1, n wraps to 0 and t decrements.
  - rd_addr is computed from the counters by a registered multiply-free running address: reverse the slot by subtracting NUM_LSTM*2-1 at the wrap, otherwise add 1.
  - On failure (mem_wr=1): rd_addr, t and n hold and the attempt repeats.
- Read latency: mem_o is valid in the cycle after a successful issue. The block captures it into the skid buffer with the issuing (t, n) tag.
- Skid buffer: 2-entry FIFO.
  - The head drives o_data, o_t, o_n, o_last and o_valid.
  - A beat transfers on o_valid & o_ready.
  - Capture and pop in the same cycle are allowed; occupancy is unchanged.
  - The credit rule guarantees the buffer never overflows. Full with inflight=1 is illegal and must be prevented by the credit check.
- Output data is not modified (no saturation or sign change). o_t and o_n are zero-extended counters.
- Throughput: 1 beat per cycle when o_ready=1 and mem_wr=0.

Optional Feature:
- Macro: HREAD_STALL_CNT_EN.
- When defined: an output port stall_cnt [15:0] is added.
  - Cleared on rst and on an accepted start.
  - Increments, saturating at 16'hFFFF, for each RUN cycle in which an issue attempt failed due to mem_wr.
  - Holds its value after done.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package lstm_mem_pkg holds:
  - the FSM state encoding (IDLE/RUN/DRAIN/DONE);
  - the address width constant ADDR_W=12;
  - the beat tag layout (t 4 bits, n ADDR_W bits, last 1 bit).
- One sub-module, h_skid_fifo: 2-entry FIFO, with parameters WIDTH and tag width, providing push, pop, count and head outputs.

Test Plan (NUM_LSTM=3, TIMESTEP=2, memory model preloaded with data[a]=32'h100+a):
- Start with o_ready=1 and mem_wr=0 -> rd_addr sequence 6,7,8,3,4,5,0,1,2. Beats 0x106,0x107,0x108,0x103,…,0x102 arrive on consecutive cycles. o_last accompanies only (t=0, n=2). done pulses once; busy falls with it.
- mem_wr forced high for 3 cycles after the second issue -> rd_addr holds at 8 for 3 cycles. Output order and values are unchanged. HREAD_STALL_CNT_EN build: stall_cnt=3.
- o_ready toggled 1010… and then held low for 5 cycles -> at most 2 beats are buffered. No beat is dropped or duplicated; the 9 beats are in order.
- start re-pulsed mid-run -> ignored; exactly 9 beats and one done pulse.
- rst asserted after 4 beats -> next cycle busy=0, o_valid=0, no done pulse. A fresh start then replays the full sequence from address 6.
- Default parameters (53, 7) -> 424 beats. The first address is 371, and the addresses of the last beats are 0..52.
